fnode_minsum_seq: RTL

- Sequencer for the polar decoder's f-node (min-sum) update.
- Reads LLR pairs alpha[i], alpha[i+len/2] from the node LLR buffer and time-shares one external 8-bit abs/negate unit (operand a, control c: c=0 → out=a, c=1 → out=-a) for three uses per pair.
- Writes beta[i] = sign(a)·sign(b)·min(|a|,|b|) to the child LLR buffer.
- Sits between the hybrid decoder's node scheduler (start/done) and the LLR memories.

---
 rtl/fnode_minsum_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fnode_minsum_seq.sv
// fnode_minsum_seq: sequencer for the polar decoder f-node (min-sum) update.
// For each pair i in 0..half-1 it reads alpha[i] and alpha[i+half], then uses
// one shared abs/negate unit three times: |a|, |b|, and the signed result.
// It writes beta[i] = sign(a)*sign(b)*min(|a|,|b|) to the child LLR buffer.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, len_log2        request and node size (2^len_log2, valid 1..LMAX)
//   rd_base, wr_base       parent and child vector base addresses
//   busy, done, err        status: busy READ..DONE, done pulse, bad-length pulse
//   rd_en, rd_addr_a/b     dual read port; rd_data_a/b valid the next cycle
//   abs_a, abs_c, abs_out  shared abs unit (c=1 negates), combinational result
//   wr_en, wr_addr, wr_data  child buffer write port
module fnode_minsum_seq #(
   parameter int unsigned W    = 8,
   parameter int unsigned AW   = 5,
   parameter int unsigned LMAX = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [2:0]    len_log2,
   input  logic [AW-1:0] rd_base,
   input  logic [AW-1:0] wr_base,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          rd_en,
   output logic [AW-1:0] rd_addr_a,
   output logic [AW-1:0] rd_addr_b,
   input  logic [W-1:0]  rd_data_a,
   input  logic [W-1:0]  rd_data_b,
   output logic [W-1:0]  abs_a,
   output logic          abs_c,
   input  logic [W-1:0]  abs_out,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [W-1:0]  wr_data
);

   typedef enum logic [2:0] {StIdle, StRead, StMagA, StMagB, StWrite, StDone} state_t;

   state_t        state;
   logic [2:0]    len_q;
   logic [AW-1:0] rd_base_q;
   logic [AW-1:0] wr_base_q;
   logic [AW-1:0] i_q;
   logic [W-1:0]  b_reg;
   logic          sa;
   logic          sb;
   logic [W-1:0]  ma;
   logic [W-1:0]  mb;

   logic [AW-1:0] half;
   logic [W-1:0]  m;
   logic          len_ok;

   assign len_ok = (len_log2 != 3'd0) && (32'(len_log2) <= LMAX);
   assign half   = AW'(1) << (len_q - 3'd1);
   // Unsigned compare is safe: both magnitudes are saturated to <= 2^(W-1)-1.
   assign m      = (ma <= mb) ? ma : mb;

   // |-2^(W-1)| is not representable; clamp so the final negation cannot overflow.
   function automatic logic [W-1:0] sat(input logic [W-1:0] x);
      if (x == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
      return x;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         len_q     <= '0;
         rd_base_q <= '0;
         wr_base_q <= '0;
         i_q       <= '0;
         b_reg     <= '0;
         sa        <= 1'b0;
         sb        <= 1'b0;
         ma        <= '0;
         mb        <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (start && len_ok) begin
                  len_q     <= len_log2;
                  rd_base_q <= rd_base;
                  wr_base_q <= wr_base;
                  i_q       <= '0;
                  state     <= StRead;
               end
            end
            StRead: state <= StMagA;
            StMagA: begin
               b_reg <= rd_data_b;
               sa    <= rd_data_a[W-1];
               sb    <= rd_data_b[W-1];
               ma    <= sat(abs_out);
               state <= StMagB;
            end
            StMagB: begin
               mb    <= sat(abs_out);
               state <= StWrite;
            end
            StWrite: begin
               if (i_q == half - AW'(1)) begin
                  state <= StDone;
               end else begin
                  i_q   <= i_q + AW'(1);
                  state <= StRead;
               end
            end
            StDone:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

   // Outputs decode the registered state; abs_a follows the read data in MAGA
   // because the memory returns it only in that cycle.
   always_comb begin
      busy      = (state != StIdle);
      done      = (state == StDone);
      err       = rst_n && (state == StIdle) && start && !len_ok;
      rd_en     = 1'b0;
      rd_addr_a = '0;
      rd_addr_b = '0;
      abs_a     = '0;
      abs_c     = 1'b0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      case (state)
         StRead: begin
            rd_en     = 1'b1;
            rd_addr_a = rd_base_q + i_q;
            rd_addr_b = rd_base_q + i_q + half;
         end
         StMagA: begin
            abs_a = rd_data_a;
            abs_c = rd_data_a[W-1];
         end
         StMagB: begin
            abs_a = b_reg;
            abs_c = sb;
         end
         StWrite: begin
            abs_a   = m;
            abs_c   = sa ^ sb;
            wr_en   = 1'b1;
            wr_addr = wr_base_q + i_q;
            wr_data = abs_out;
         end
         default: ;
      endcase
   end

endmodule
